logic_capture_ng: RTL and testbench

LOGIC_CAPTURE_NG -- requirements
Module: logic_capture_ng

---
 rtl/logic_capture_pkg.sv | 18 +
 rtl/logic_capture_ng_if.sv | 13 +
 rtl/lc_sync_edge.sv | 35 +++
 rtl/logic_capture_ng.sv | 154 +++++++++++++++
 tb/tb_logic_capture_ng.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_capture_pkg.sv
// Shared types for the logic capture block: state encoding seen on state_o.
// Optional feature macro: LOGIC_CAPTURE_TIMESTAMP_EN (adds a delta field to each entry).
package logic_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } lc_state_t;

`ifdef LOGIC_CAPTURE_TIMESTAMP_EN
  localparam bit LC_TS_EN = 1'b1;
`else
  localparam bit LC_TS_EN = 1'b0;
`endif

endpackage

// File: rtl/logic_capture_ng_if.sv
// Capture-memory write port: strobes, address and entry word.
interface logic_capture_ng_if #(
  parameter int ADDR_W = 18,
  parameter int MEM_W  = 8
) ();
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_wdata;

  modport master (output mem_en, output mem_we, output mem_addr, output mem_wdata);
  modport slave  (input  mem_en, input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/lc_sync_edge.sv
// Probe front end: two-flop synchroniser, compare register, per-channel edge vectors.
module lc_sync_edge #(
  parameter int CH_W = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [CH_W-1:0] datain,
  output logic [CH_W-1:0] sample,
  output logic [CH_W-1:0] rise,
  output logic [CH_W-1:0] fall
);
  logic [CH_W-1:0] sync_p0;
  logic [CH_W-1:0] sync_p1;
  logic [CH_W-1:0] prev_p2;

  // Synchronise the asynchronous probes, then keep the previous synchronised value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      prev_p2 <= '0;
    end else begin
      // p0 -> p1: metastability settling
      sync_p0 <= datain;
      sync_p1 <= sync_p0;
      // p1 -> p2: compare register for edge detection
      prev_p2 <= sync_p1;
    end
  end

  assign sample = sync_p1;
  assign rise   = sync_p1 & ~prev_p2;
  assign fall   = ~sync_p1 & prev_p2;

endmodule

// File: rtl/logic_capture_ng.sv
// Logic analyser capture engine: arms on start, triggers on masked edges, then
// records every change of the probe vector into a linear capture memory.
// Optional feature macro: LOGIC_CAPTURE_TIMESTAMP_EN prepends a delta counter to
// each entry and forces a keep-alive entry when the delta saturates.
module logic_capture_ng
  import logic_capture_pkg::*;
#(
  parameter int CH_W   = 8,
  parameter int ADDR_W = 18,
  parameter int TS_W   = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                stop,
  input  logic [CH_W-1:0]     trig_rise_mask,
  input  logic [CH_W-1:0]     trig_fall_mask,
  input  logic [CH_W-1:0]     datain,
  logic_capture_ng_if.master  mem,
  output logic [1:0]          state_o,
  output logic [ADDR_W:0]     wr_count,
  output logic                full
);

`ifdef LOGIC_CAPTURE_TIMESTAMP_EN
  localparam int MEM_W = TS_W + CH_W;
`else
  localparam int MEM_W = CH_W;
`endif

  // The delta width only matters with timestamps, but keep it legal in every build.
  if (TS_W < 1) begin : g_ts_w_check
    $error("logic_capture_ng: TS_W must be at least 1");
  end

  lc_state_t         state_q, state_d;
  logic [CH_W-1:0]   sample, rise, fall;
  logic              trig_hit, change, keep_alive, last_addr;
  logic              wr_fire, arm;
  logic [MEM_W-1:0]  wr_word;
  logic              wr_stb_p3;
  logic [ADDR_W-1:0] addr_q;
  logic [MEM_W-1:0]  wdata_q;
  logic [ADDR_W:0]   wr_cnt_q;
  logic              full_q;

  lc_sync_edge #(.CH_W(CH_W)) u_sync_edge (
    .clk    (clk),
    .resetn (resetn),
    .datain (datain),
    .sample (sample),
    .rise   (rise),
    .fall   (fall)
  );

  // With both masks clear the engine triggers immediately on the current sample.
  assign trig_hit  = (|((rise & trig_rise_mask) | (fall & trig_fall_mask))) ||
                     ((trig_rise_mask == '0) && (trig_fall_mask == '0));
  assign change    = |(rise | fall);
  // The next write lands on the last memory location; the run ends there.
  assign last_addr = (wr_cnt_q[ADDR_W-1:0] == '1);

`ifdef LOGIC_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] delta_q;

  function automatic logic [TS_W-1:0] delta_step(input logic [TS_W-1:0] d);
    return (d == '1) ? d : d + 1'b1;
  endfunction

  assign keep_alive = (delta_q == '1);
  assign wr_word    = {delta_q, sample};

  // Delta counts idle capture cycles; cleared on arming and on every write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      delta_q <= '0;
    end else if (arm || wr_fire) begin
      delta_q <= '0;
    end else if (state_q == ST_CAPTURE) begin
      delta_q <= delta_step(delta_q);
    end
  end
`else
  assign keep_alive = 1'b0;
  assign wr_word    = sample;
`endif

  // Run-control next state and write decision; stop overrides start everywhere.
  always_comb begin
    state_d = state_q;
    wr_fire = 1'b0;
    arm     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && !stop) begin
          state_d = ST_ARMED;
          arm     = 1'b1;
        end
      end
      ST_ARMED: begin
        if (trig_hit) begin
          wr_fire = 1'b1;
          state_d = ST_CAPTURE;
        end
        if (stop) state_d = ST_DONE;
      end
      ST_CAPTURE: begin
        if (change || keep_alive) wr_fire = 1'b1;
        if (stop) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (wr_fire && last_addr) state_d = ST_DONE;
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Write port and run bookkeeping; address/data hold between writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_stb_p3 <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_cnt_q  <= '0;
      full_q    <= 1'b0;
    end else begin
      // p2 -> p3: registered write strobe, one cycle per accepted change
      wr_stb_p3 <= wr_fire;
      if (arm) begin
        addr_q   <= '0;
        wr_cnt_q <= '0;
        full_q   <= 1'b0;
      end else if (wr_fire) begin
        addr_q   <= wr_cnt_q[ADDR_W-1:0];
        wdata_q  <= wr_word;
        wr_cnt_q <= wr_cnt_q + 1'b1;
        if (last_addr) full_q <= 1'b1;
      end
    end
  end

  assign mem.mem_en    = wr_stb_p3;
  assign mem.mem_we    = wr_stb_p3;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign state_o       = state_q;
  assign wr_count      = wr_cnt_q;
  assign full          = full_q;

endmodule

// File: tb/tb_logic_capture_ng.sv
// Bench for logic_capture_ng: reference model pushes expected memory writes into a
// queue at each clock; an independent monitor pops them when the DUT strobes.
module tb_logic_capture_ng;
  localparam int CH_W   = 8;
  localparam int ADDR_W = 4;
  localparam int TS_W   = 4;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef LOGIC_CAPTURE_TIMESTAMP_EN
  localparam int MEM_W = TS_W + CH_W;
  localparam bit TS_ON = 1'b1;
`else
  localparam int MEM_W = CH_W;
  localparam bit TS_ON = 1'b0;
`endif

  localparam int M_IDLE = 0, M_ARMED = 1, M_CAP = 2, M_DONE = 3;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start, stop;
  logic [CH_W-1:0]   rmask, fmask, datain;
  logic [1:0]        state_o;
  logic [ADDR_W:0]   wr_count;
  logic              full;

  logic_capture_ng_if #(.ADDR_W(ADDR_W), .MEM_W(MEM_W)) mif ();

  logic_capture_ng #(.CH_W(CH_W), .ADDR_W(ADDR_W), .TS_W(TS_W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .start          (start),
    .stop           (stop),
    .trig_rise_mask (rmask),
    .trig_fall_mask (fmask),
    .datain         (datain),
    .mem            (mif),
    .state_o        (state_o),
    .wr_count       (wr_count),
    .full           (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    logic [ADDR_W-1:0] addr;
    logic [MEM_W-1:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: what the capture run should look like, in plain terms.
  int            m_state = M_IDLE;
  int            m_cnt   = 0;
  int            m_addr  = 0;
  int            m_delta = 0;
  bit            m_full  = 1'b0;
  logic [CH_W-1:0] seen[$];   // probe values taken at past clocks, newest first

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A probe value taken at clock k is judged against the value at clock k-1 two
  // clocks later; the resulting write is visible in the cycle after that clock.
  task automatic model_step();
    logic [CH_W-1:0] cur, prev, rise, fall;
    bit              trig, chg, wr;
    int              next;
    exp_t            e;
    cyc++;
    if (!resetn) begin
      m_state = M_IDLE; m_cnt = 0; m_addr = 0; m_delta = 0; m_full = 1'b0;
      seen = '{'0, '0, '0};
      exp_q.delete();
      return;
    end
    cur  = seen[1];
    prev = seen[2];
    rise = cur & ~prev;
    fall = ~cur & prev;
    chg  = (cur != prev);
    trig = ((rise & rmask) != 0) || ((fall & fmask) != 0) || (rmask == 0 && fmask == 0);
    wr   = 1'b0;
    next = m_state;
    if (m_state == M_IDLE || m_state == M_DONE) begin
      if (start && !stop) begin
        next = M_ARMED; m_cnt = 0; m_addr = 0; m_delta = 0; m_full = 1'b0;
      end
    end else begin
      if (m_state == M_ARMED && trig) begin
        wr = 1'b1; next = M_CAP;
      end
      if (m_state == M_CAP && (chg || (TS_ON && m_delta == (1 << TS_W) - 1))) wr = 1'b1;
      if (stop) next = M_DONE;
    end
    if (wr) begin
      e.cyc  = cyc;
      e.addr = ADDR_W'(m_cnt);
`ifdef LOGIC_CAPTURE_TIMESTAMP_EN
      e.data = {TS_W'(m_delta), cur};
`else
      e.data = cur;
`endif
      exp_q.push_back(e);
      m_addr  = m_cnt;
      m_cnt   = m_cnt + 1;
      m_delta = 0;
      if (m_cnt == DEPTH) begin
        m_full = 1'b1; next = M_DONE;
      end
    end else if (m_state == M_CAP) begin
      m_delta = m_delta + 1;
    end
    m_state = next;
    seen.push_front(datain);
    void'(seen.pop_back());
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: consume an expected entry whenever the DUT strobes, flag stale ones.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!resetn) begin
      chk("rst_mem_en", mif.mem_en, 0);
      chk("rst_mem_we", mif.mem_we, 0);
      chk("rst_mem_addr", mif.mem_addr, 0);
      chk("rst_mem_wdata", mif.mem_wdata, 0);
      chk("rst_state", state_o, 0);
      chk("rst_wr_count", wr_count, 0);
      chk("rst_full", full, 0);
    end else begin
      if (mif.mem_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: got addr %0h data %0h expected no write (cycle %0d)",
                   mif.mem_addr, mif.mem_wdata, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("wr_cycle", 64'(cyc), 64'(e.cyc));
          chk("wr_we", mif.mem_we, 1);
          chk("wr_addr", mif.mem_addr, e.addr);
          chk("wr_data", mif.mem_wdata, e.data);
        end
      end
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_strobe: got mem_en %0b expected write addr %0h data %0h (cycle %0d)",
                 mif.mem_en, e.addr, e.data, cyc);
      end
      if (mif.mem_en !== 1'b1) chk("idle_we", mif.mem_we, 0);
      chk("state", state_o, m_state);
      chk("wr_count", wr_count, m_cnt);
      chk("full", full, m_full);
      chk("addr_hold", mif.mem_addr, m_addr);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; stop = 1'b0;
    rmask = '0; fmask = '0; datain = '0;
    tick(3);
    resetn = 1'b1;
    tick(3);

    // Rising-edge trigger on channel 0: one write of 0x01 at address 0.
    rmask = 8'h01; fmask = 8'h00;
    pulse_start();
    tick(3);
    datain = 8'h01;
    tick(4);
    chk("trig_state", state_o, M_CAP);
    chk("trig_wr_count", wr_count, 1);
    chk("trig_addr", mif.mem_addr, 0);
    chk("trig_data_ch", mif.mem_wdata[CH_W-1:0], 8'h01);

    // Back-to-back changes: four consecutive writes at addresses 1..4.
    for (int i = 0; i < 4; i++) begin
      datain = (i % 2 == 0) ? 8'h55 : 8'hAA;
      tick();
    end
    tick(4);
    chk("b2b_wr_count", wr_count, 5);
    chk("b2b_last_addr", mif.mem_addr, 4);

    // Fill the whole memory with continuous toggling; no write beyond the last slot.
    pulse_stop();
    tick(2);
    rmask = '0; fmask = '0;
    pulse_start();
    for (int i = 0; i < 24; i++) begin
      datain = (datain == 8'h55) ? 8'hAA : 8'h55;
      tick();
    end
    tick(4);
    chk("fill_full", full, 1);
    chk("fill_wr_count", wr_count, DEPTH);
    chk("fill_state", state_o, M_DONE);

    // Start and stop together while armed: stop wins, nothing written.
    rmask = 8'h80; fmask = 8'h00;
    pulse_start();
    tick(2);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick(4);
    chk("ss_state", state_o, M_DONE);
    chk("ss_wr_count", wr_count, 0);
    chk("ss_full", full, 0);

    // Static input after an immediate trigger (keep-alive entries with timestamps).
    rmask = '0; fmask = '0;
    pulse_start();
    tick(40);
    pulse_stop();
    tick(3);

    // Randomised runs with random masks, data, and stray start/stop pulses.
    for (int r = 0; r < 8; r++) begin
      rmask = ($urandom_range(0, 3) == 0) ? '0 : CH_W'($urandom);
      fmask = ($urandom_range(0, 3) == 0) ? '0 : CH_W'($urandom);
      pulse_start();
      for (int j = 0; j < 30; j++) begin
        if ($urandom_range(0, 1) == 1) datain = CH_W'($urandom);
        stop  = ($urandom_range(0, 24) == 0);
        start = ($urandom_range(0, 24) == 0);
        tick();
      end
      start = 1'b0;
      stop  = 1'b1;
      tick();
      stop  = 1'b0;
      tick(4);
    end

    // Reset pulse in the middle of a capture: everything clears, no strobe afterwards.
    rmask = '0; fmask = '0;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      datain = ~datain;
      tick();
    end
    resetn = 1'b0;
    tick();
    chk("midrst_state", state_o, 0);
    chk("midrst_mem_en", mif.mem_en, 0);
    chk("midrst_wr_count", wr_count, 0);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      datain = ~datain;
      tick();
    end
    chk("post_rst_state", state_o, M_IDLE);

    tick(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
